imem_arbiter: RTL
=================

Name: imem_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the instruction-fetch stage (reads) and the UART program loader (writes).
- In boot mode the loader owns the memory and the core is stalled.
- In run mode fetch has priority, and the loader gets bounded-starvation access for runtime patch writes.
- Sits between the fetch stage, the loader and the program memory; generates the fetch stall.

Parameters:
- ADDR_WIDTH, 14, word-address width of instruction memory
- DATA_WIDTH, 32, instruction word width
- STARVE_LIMIT, 4, max consecutive fetch grants while loader waits before loader is forced a slot (1..15)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- boot_mode  in  1  1 = loader owns memory, core paused
- f_req  in  1  fetch read request
- f_addr  in  ADDR_WIDTH  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  f_rdata valid (one cycle after f_gnt)
- f_rdata  out  DATA_WIDTH  fetched instruction
- l_wvalid  in  1  loader write request
- l_waddr  in  ADDR_WIDTH  loader word address
- l_wdata  in  DATA_WIDTH  loader write data
- l_wready  out  1  loader write accepted this cycle
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, 1-cycle latency
- core_stall  out  1  hold PC/instruction register
- load_done  out  1  one-cycle pulse on BOOT->RUN
- perf_stall_cnt  out  32  see Optional Feature
- perf_load_cnt  out  32  see Optional Feature

Behaviour:
- States: BOOT, RUN, DRAIN. Reset (reset=0) forces BOOT, starve_cnt=0, f_rvalid=0, load_done=0. While reset=0, f_gnt, l_wready, mem_en and mem_we are 0, and core_stall=1.
- BOOT: f_gnt=0; core_stall=1. l_wready=l_wvalid. On l_wvalid: mem_en=1, mem_we=1, mem_addr=l_waddr, mem_wdata=l_wdata.
  - BOOT->RUN when boot_mode=0 and l_wvalid=0; load_done=1 for exactly the first RUN cycle.
  - If boot_mode=0 but l_wvalid=1, the write is accepted and the transition waits.
- RUN: grant decision is combinational, same cycle.
  - loader_win = l_wvalid & (~f_req | starve_cnt==STARVE_LIMIT).
  - Loader win: l_wready=1, f_gnt=0, write as in BOOT.
  - Else if f_req: f_gnt=1, mem_en=1, mem_we=0, mem_addr=f_addr.
  - Neither request: mem_en=0.
- starve_cnt (4 bits):
  - +1 on a cycle with f_gnt=1 and l_wvalid=1.
  - Clears on l_wready=1 or when l_wvalid=0.
  - Saturates at STARVE_LIMIT.
- f_rvalid is a register: f_rvalid <= f_gnt. f_rdata = mem_rdata (pass-through). Read latency: address accepted cycle N, data valid cycle N+1.
- core_stall = (state!=RUN) | (f_req & ~f_gnt).
- RUN->DRAIN when boot_mode=1. No grants in DRAIN; the in-flight read still returns f_rvalid. DRAIN->BOOT next cycle unconditionally.
- Simultaneous requests at the limit: loader wins once, counter clears, fetch wins the next cycle.
- boot_mode toggling 1->0->1 across BOOT/RUN is handled only through the state rules above; no grant is ever issued in DRAIN.
- Address wrap: none; addresses are passed through unmodified.

Optional Feature:
- Macro IMEM_ARB_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every RUN cycle with f_req & ~f_gnt.
  - perf_load_cnt increments on every accepted loader write.
  - Both are 32-bit, wrap at 2^32, and clear on reset only.
- Undefined: both ports are tied to 0 and no counter registers are built.

Test Plan:
- Reset released with boot_mode=1; loader writes 0x3C010000 to addr 0 and 0x00000000 to addr 1 -> l_wready=1 each cycle, mem_we=1, f_gnt=0, core_stall=1.
- boot_mode 1->0 with l_wvalid=0 -> load_done pulses 1 cycle; fetch addr 0 in cycle N -> f_rvalid=1, f_rdata=0x3C010000 in cycle N+1.
- RUN, f_req held 1, l_wvalid held 1, STARVE_LIMIT=4 -> 4 fetch grants, then 1 loader grant (core_stall=1 that cycle), then fetch resumes.
- RUN, fetch granted cycle N, boot_mode=1 in cycle N -> DRAIN at N+1 with f_rvalid=1 and no grants, BOOT at N+2.
- reset pulled low mid-write in RUN -> mem_we=0, f_rvalid=0 and core_stall=1 immediately (asynchronous); state BOOT after release.
- IMEM_ARB_PERF_EN defined, 3 stalled fetch cycles and 2 loader writes -> perf_stall_cnt=3, perf_load_cnt=2.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Instruction-memory arbiter bus: fetch port, loader write port and the memory port.
// The arbiter takes the slave modport; fetch, loader and memory models use master.
interface imem_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [DATA_WIDTH-1:0] f_rdata;

    logic                  l_wvalid;
    logic [ADDR_WIDTH-1:0] l_waddr;
    logic [DATA_WIDTH-1:0] l_wdata;
    logic                  l_wready;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, l_wvalid, l_waddr, l_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, l_wready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, l_wvalid, l_waddr, l_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_wready,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: loader owns memory in boot, fetch has priority in run.
// Optional performance counters are built when IMEM_ARB_PERF_EN is defined.
module imem_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    input  logic          boot_mode_i,
    imem_arbiter_if.slave bus,
    output logic          core_stall_o,
    output logic          load_done_o,
    output logic [31:0]   perf_stall_cnt_o,
    output logic [31:0]   perf_load_cnt_o
);
    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q;
    logic [3:0] starve_q, starve_d;
    logic       f_rvalid_q;
    logic       load_done_q;

    logic       loader_win;
    logic       f_gnt;
    logic       l_wready;
    logic       mem_en;
    logic       mem_we;

    // Grants are combinational and forced low while reset is asserted.
    always_comb begin
        f_gnt      = 1'b0;
        l_wready   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        loader_win = bus.l_wvalid & (~bus.f_req | (starve_q == LIMIT));
        if (reset_ni) begin
            unique case (state_q)
                BOOT: begin
                    l_wready = bus.l_wvalid;
                    mem_en   = bus.l_wvalid;
                    mem_we   = bus.l_wvalid;
                end
                RUN: begin
                    if (loader_win) begin
                        l_wready = 1'b1;
                        mem_en   = 1'b1;
                        mem_we   = 1'b1;
                    end else if (bus.f_req) begin
                        f_gnt  = 1'b1;
                        mem_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (l_wready || !bus.l_wvalid) begin
            starve_d = 4'd0;
        end else if (f_gnt && starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= BOOT;
            starve_q    <= 4'd0;
            f_rvalid_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            f_rvalid_q  <= f_gnt;
            load_done_q <= 1'b0;
            unique case (state_q)
                BOOT: begin
                    // A pending loader write holds off the switch to run.
                    if (!boot_mode_i && !bus.l_wvalid) begin
                        state_q     <= RUN;
                        load_done_q <= 1'b1;
                    end
                end
                RUN:     if (boot_mode_i) state_q <= DRAIN;
                DRAIN:   state_q <= BOOT;
                default: state_q <= BOOT;
            endcase
        end
    end

    assign bus.f_gnt     = f_gnt;
    assign bus.l_wready  = l_wready;
    assign bus.f_rvalid  = f_rvalid_q;
    assign bus.f_rdata   = bus.mem_rdata;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_we ? bus.l_waddr : bus.f_addr;
    assign bus.mem_wdata = bus.l_wdata;

    assign core_stall_o = ~reset_ni | (state_q != RUN) | (bus.f_req & ~f_gnt);
    assign load_done_o  = load_done_q;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_load_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            perf_stall_q <= 32'd0;
            perf_load_q  <= 32'd0;
        end else begin
            if (state_q == RUN && bus.f_req && !f_gnt) perf_stall_q <= perf_stall_q + 32'd1;
            if (l_wready)                              perf_load_q  <= perf_load_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_load_cnt_o  = perf_load_q;
`else
    assign perf_stall_cnt_o = 32'd0;
    assign perf_load_cnt_o  = 32'd0;
`endif
endmodule
